// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
//
// Shared definitions for the DDR receive/transmit datapath:
//   - receive mode codes driven by the DDR/CCC controller
//   - number of SDA bits carried by each field
//   - the fixed token pattern
//   - the receiver FSM state type
//   - helpers mapping a mode code to its validity and its bit count
// ---------------------------------------------------------------------------
package ddr_pkg;

    // Receive mode codes
    localparam logic [3:0] RX_MODE_PREAMBLE = 4'b0001;
    localparam logic [3:0] RX_MODE_BYTE     = 4'b0100;
    localparam logic [3:0] RX_MODE_PARITY   = 4'b0101;
    localparam logic [3:0] RX_MODE_CRC      = 4'b0110;
    localparam logic [3:0] RX_MODE_TOKEN    = 4'b0111;

    // Bits per field
    localparam logic [3:0] PREAMBLE_BITS = 4'd2;
    localparam logic [3:0] BYTE_BITS     = 4'd8;
    localparam logic [3:0] PARITY_BITS   = 4'd2;
    localparam logic [3:0] TOKEN_BITS    = 4'd4;
    localparam logic [3:0] CRC_BITS      = 4'd5;

    // Pattern every token field must carry
    localparam logic [3:0] TOKEN_VALUE = 4'b1100;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SAMPLE,
        RX_DONE
    } rx_state_t;

    function automatic logic is_valid_rx_mode(input logic [3:0] mode);
        logic valid;
        valid = 1'b0;
        case (mode)
            RX_MODE_PREAMBLE,
            RX_MODE_BYTE,
            RX_MODE_PARITY,
            RX_MODE_CRC,
            RX_MODE_TOKEN:    valid = 1'b1;
            default:          valid = 1'b0;
        endcase
        return valid;
    endfunction

    function automatic logic [3:0] rx_mode_bits(input logic [3:0] mode);
        logic [3:0] bits;
        bits = 4'd0;
        case (mode)
            RX_MODE_PREAMBLE: bits = PREAMBLE_BITS;
            RX_MODE_BYTE:     bits = BYTE_BITS;
            RX_MODE_PARITY:   bits = PARITY_BITS;
            RX_MODE_CRC:      bits = CRC_BITS;
            RX_MODE_TOKEN:    bits = TOKEN_BITS;
            default:          bits = 4'd0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/ddr_parity_calc.sv
// ---------------------------------------------------------------------------
// ddr_parity_calc
//
// Combinational two-bit parity over a 16-bit data word {D1,D2}. Shared by the
// receive and transmit sides so both compute the same parity.
//
// Ports:
//   data_word  in  16  data word, D1 in [15:8], D2 in [7:0]
//   parity     out 2   [1] = XOR of odd bits, [0] = XNOR of even bits
// ---------------------------------------------------------------------------
module ddr_parity_calc (
    input  logic [15:0] data_word,
    output logic [1:0]  parity
);

    // PA0 is inverted so an all-zero word never produces all-zero parity.
    assign parity[1] = ^(data_word & 16'hAAAA);
    assign parity[0] = ~(^(data_word & 16'h5555));

endmodule

// File: rtl/ddr_rx.sv
// ---------------------------------------------------------------------------
// ddr_rx
//
// DDR field receiver. Samples one SDA bit on every SCL edge strobe (rising or
// falling, simultaneous strobes count once), MSB first, for the number of bits
// of the mode latched at field start, then pulses done for one cycle together
// with the field's result (preamble, byte, or parity/token/CRC error).
//
// Configuration:
//   RX_CRC_CHECK_EN  defined   -> CRC field compared with i_crc_crc_value
//                    undefined -> CRC field sampled, never flagged as error
//
// Ports:
//   i_sys_clk                in  1  clock, rising edge
//   i_sys_rst                in  1  synchronous active-high reset
//   i_ddrccc_rx_en           in  1  enable; low aborts a field in progress
//   i_ddrccc_rx_mode         in  4  field type (ddr_pkg RX_MODE_*)
//   i_sclgen_scl_pos_edge    in  1  SCL rising-edge strobe
//   i_sclgen_scl_neg_edge    in  1  SCL falling-edge strobe
//   i_sdahnd_rx_sda          in  1  synchronised SDA
//   i_crc_crc_value          in  5  CRC5 computed over received data
//   o_ddrccc_rx_mode_done    out 1  one-cycle field-complete pulse
//   o_ddrccc_preamble        out 2  last received preamble
//   o_ddrccc_error           out 1  parity/token/CRC error, with done
//   o_regf_rx_parallel_data  out 8  last received byte
//   o_regf_wr_en             out 1  byte valid pulse
//   o_crc_parallel_data      out 8  byte forwarded to CRC engine
//   o_crc_en                 out 1  CRC byte valid pulse
// ---------------------------------------------------------------------------
module ddr_rx
    import ddr_pkg::*;
(
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_ddrccc_rx_en,
    input  logic [3:0] i_ddrccc_rx_mode,
    input  logic       i_sclgen_scl_pos_edge,
    input  logic       i_sclgen_scl_neg_edge,
    input  logic       i_sdahnd_rx_sda,
    input  logic [4:0] i_crc_crc_value,
    output logic       o_ddrccc_rx_mode_done,
    output logic [1:0] o_ddrccc_preamble,
    output logic       o_ddrccc_error,
    output logic [7:0] o_regf_rx_parallel_data,
    output logic       o_regf_wr_en,
    output logic [7:0] o_crc_parallel_data,
    output logic       o_crc_en
);

    rx_state_t  state;
    rx_state_t  state_next;

    logic [3:0] mode_q;
    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] shift_next;
    logic [3:0] last_bit;

    logic       scl_edge;
    logic       start_field;
    logic       abort_field;
    logic       sample_bit;
    logic       final_sample;
    logic       field_error;

    // Data word used for the parity check; byte_sel_q = 0 selects D1.
    logic [7:0] d1_q;
    logic [7:0] d2_q;
    logic       byte_sel_q;
    logic [1:0] parity_expected;

    logic       error_q;
    logic       wr_en_q;
    logic       crc_en_q;
    logic [1:0] preamble_q;
    logic [7:0] regf_data_q;
    logic [7:0] crc_data_q;

    assign scl_edge     = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign shift_next   = {shift_q[6:0], i_sdahnd_rx_sda};
    assign last_bit     = rx_mode_bits(mode_q) - 4'd1;

    assign start_field  = (state == RX_IDLE) && i_ddrccc_rx_en
                          && is_valid_rx_mode(i_ddrccc_rx_mode);
    assign abort_field  = (state != RX_IDLE) && !i_ddrccc_rx_en;
    assign sample_bit   = (state == RX_SAMPLE) && i_ddrccc_rx_en && scl_edge;
    assign final_sample = sample_bit && (bit_cnt == last_bit);

    ddr_parity_calc u_parity_calc (
        .data_word (
            {d1_q, d2_q}
        ),
        .parity    (parity_expected)
    );

    // Field check evaluated on the final bit, using the bit being sampled now,
    // so the error lines up with the cycle the FSM spends in DONE.
`ifdef RX_CRC_CHECK_EN
    always_comb begin
        field_error = 1'b0;
        case (mode_q)
            RX_MODE_PARITY: field_error = (shift_next[1:0] != parity_expected);
            RX_MODE_TOKEN:  field_error = (shift_next[3:0] != TOKEN_VALUE);
            RX_MODE_CRC:    field_error = (shift_next[4:0] != i_crc_crc_value);
            default:        field_error = 1'b0;
        endcase
    end
`else
    logic crc_value_unused;
    assign crc_value_unused = ^i_crc_crc_value;

    always_comb begin
        field_error = 1'b0;
        case (mode_q)
            RX_MODE_PARITY: field_error = (shift_next[1:0] != parity_expected);
            RX_MODE_TOKEN:  field_error = (shift_next[3:0] != TOKEN_VALUE);
            default:        field_error = 1'b0;
        endcase
    end
`endif

    // FSM state register.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Dropping the enable wins over a final bit arriving
    // in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (start_field) begin
                    state_next = RX_SAMPLE;
                end
            end
            RX_SAMPLE: begin
                if (!i_ddrccc_rx_en) begin
                    state_next = RX_IDLE;
                end else if (final_sample) begin
                    state_next = RX_DONE;
                end
            end
            RX_DONE: begin
                state_next = RX_IDLE;
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    // Mode latch, bit counter and shift register. The mode is captured only
    // at field start so controller mode changes mid-field have no effect.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            mode_q  <= 4'd0;
            bit_cnt <= 4'd0;
            shift_q <= 8'd0;
        end else if (start_field) begin
            mode_q  <= i_ddrccc_rx_mode;
            bit_cnt <= 4'd0;
            shift_q <= 8'd0;
        end else if (abort_field) begin
            bit_cnt <= 4'd0;
        end else if (sample_bit) begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // D1/D2 storage: bytes alternate between D1 and D2; a parity field or an
    // abort returns the select to D1 for the next data word.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            d1_q       <= 8'd0;
            d2_q       <= 8'd0;
            byte_sel_q <= 1'b0;
        end else if (abort_field) begin
            byte_sel_q <= 1'b0;
        end else if (final_sample) begin
            if (mode_q == RX_MODE_BYTE) begin
                if (!byte_sel_q) begin
                    d1_q <= shift_next;
                end else begin
                    d2_q <= shift_next;
                end
                byte_sel_q <= ~byte_sel_q;
            end else if (mode_q == RX_MODE_PARITY) begin
                byte_sel_q <= 1'b0;
            end
        end
    end

    // Result registers. Pulses default low every cycle; data and preamble
    // hold until the next completed field of their type.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            error_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            crc_en_q    <= 1'b0;
            preamble_q  <= 2'd0;
            regf_data_q <= 8'd0;
            crc_data_q  <= 8'd0;
        end else begin
            error_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            crc_en_q <= 1'b0;
            if (final_sample) begin
                error_q <= field_error;
                if (mode_q == RX_MODE_PREAMBLE) begin
                    preamble_q <= shift_next[1:0];
                end
                if (mode_q == RX_MODE_BYTE) begin
                    regf_data_q <= shift_next;
                    crc_data_q  <= shift_next;
                    wr_en_q     <= 1'b1;
                    crc_en_q    <= 1'b1;
                end
            end
        end
    end

    assign o_ddrccc_rx_mode_done   = (state == RX_DONE);
    assign o_ddrccc_error          = error_q;
    assign o_ddrccc_preamble       = preamble_q;
    assign o_regf_rx_parallel_data = regf_data_q;
    assign o_regf_wr_en            = wr_en_q;
    assign o_crc_parallel_data     = crc_data_q;
    assign o_crc_en                = crc_en_q;

endmodule

// File: tb/tb_ddr_rx.sv
// ---------------------------------------------------------------------------
// tb_ddr_rx
//
// Directed bench for ddr_rx. Each test pushes the expected field result to a
// scoreboard queue before driving the field and pops it when done is seen.
// Follows RX_CRC_CHECK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_ddr_rx;

    localparam logic [3:0] M_PRE    = 4'b0001;
    localparam logic [3:0] M_BYTE   = 4'b0100;
    localparam logic [3:0] M_PARITY = 4'b0101;
    localparam logic [3:0] M_CRC    = 4'b0110;
    localparam logic [3:0] M_TOKEN  = 4'b0111;

    // Edge kinds for drive_field
    localparam int EDGE_BOTH = 2;
    localparam int EDGE_ALT  = 3;

    typedef struct packed {
        logic       done;
        logic       err;
        logic       wr;
        logic       crc_en;
        logic [7:0] rdata;
        logic [7:0] cdata;
        logic [1:0] pre;
    } obs_t;

    logic       i_sys_clk;
    logic       i_sys_rst;
    logic       i_ddrccc_rx_en;
    logic [3:0] i_ddrccc_rx_mode;
    logic       i_sclgen_scl_pos_edge;
    logic       i_sclgen_scl_neg_edge;
    logic       i_sdahnd_rx_sda;
    logic [4:0] i_crc_crc_value;
    logic       o_ddrccc_rx_mode_done;
    logic [1:0] o_ddrccc_preamble;
    logic       o_ddrccc_error;
    logic [7:0] o_regf_rx_parallel_data;
    logic       o_regf_wr_en;
    logic [7:0] o_crc_parallel_data;
    logic       o_crc_en;

    int   checks;
    int   errors;
    obs_t exp_q[$];
    logic [1:0] exp_pre;
    logic [7:0] exp_data;
    obs_t last_obs;
    logic last_early;
    logic [2:0] last_after;

    ddr_rx dut (
        .i_sys_clk               (i_sys_clk),
        .i_sys_rst               (i_sys_rst),
        .i_ddrccc_rx_en          (i_ddrccc_rx_en),
        .i_ddrccc_rx_mode        (i_ddrccc_rx_mode),
        .i_sclgen_scl_pos_edge   (i_sclgen_scl_pos_edge),
        .i_sclgen_scl_neg_edge   (i_sclgen_scl_neg_edge),
        .i_sdahnd_rx_sda         (i_sdahnd_rx_sda),
        .i_crc_crc_value         (i_crc_crc_value),
        .o_ddrccc_rx_mode_done   (o_ddrccc_rx_mode_done),
        .o_ddrccc_preamble       (o_ddrccc_preamble),
        .o_ddrccc_error          (o_ddrccc_error),
        .o_regf_rx_parallel_data (o_regf_rx_parallel_data),
        .o_regf_wr_en            (o_regf_wr_en),
        .o_crc_parallel_data     (o_crc_parallel_data),
        .o_crc_en                (o_crc_en)
    );

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    function automatic obs_t sample_outputs();
        obs_t o;
        o.done   = o_ddrccc_rx_mode_done;
        o.err    = o_ddrccc_error;
        o.wr     = o_regf_wr_en;
        o.crc_en = o_crc_en;
        o.rdata  = o_regf_rx_parallel_data;
        o.cdata  = o_crc_parallel_data;
        o.pre    = o_ddrccc_preamble;
        return o;
    endfunction

    // Expected outputs in the DONE cycle, from the bench's tracked data state.
    function automatic obs_t make_exp(input logic err, input logic wr);
        obs_t o;
        o.done   = 1'b1;
        o.err    = err;
        o.wr     = wr;
        o.crc_en = wr;
        o.rdata  = exp_data;
        o.cdata  = exp_data;
        o.pre    = exp_pre;
        return o;
    endfunction

    function automatic logic [1:0] model_parity(input logic [15:0] w);
        logic p1;
        logic p0;
        p1 = 1'b0;
        p0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) p1 = p1 ^ w[i];
            else            p0 = p0 ^ w[i];
        end
        return {p1, p0};
    endfunction

    // Drives one complete field (MSB first), one idle cycle between edges.
    // The mode input switches to mid_mode after the first bit.
    task automatic drive_field(input logic [3:0] mode, input logic [7:0] bits,
                               input int n, input int kind,
                               input logic [3:0] mid_mode);
        last_early = 1'b0;
        i_ddrccc_rx_en   = 1'b1;
        i_ddrccc_rx_mode = mode;
        tick();
        for (int i = 0; i < n; i++) begin
            i_sdahnd_rx_sda       = bits[n-1-i];
            i_sclgen_scl_pos_edge = (kind == EDGE_BOTH) || (kind == EDGE_ALT && i % 2 == 0);
            i_sclgen_scl_neg_edge = (kind == EDGE_BOTH) || (kind == EDGE_ALT && i % 2 == 1);
            tick();
            i_sclgen_scl_pos_edge = 1'b0;
            i_sclgen_scl_neg_edge = 1'b0;
            if (i == 0) i_ddrccc_rx_mode = mid_mode;
            if (i < n - 1) begin
                if (o_ddrccc_rx_mode_done) last_early = 1'b1;
                tick();
                if (o_ddrccc_rx_mode_done) last_early = 1'b1;
            end
        end
        last_obs = sample_outputs();
        tick();
        last_after = {o_ddrccc_rx_mode_done, o_regf_wr_en, o_crc_en};
        i_ddrccc_rx_en   = 1'b0;
        i_ddrccc_rx_mode = 4'd0;
    endtask

    task automatic test_reset();
        obs_t got;
        i_sys_rst = 1'b1;
        tick();
        tick();
        got = sample_outputs();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", got, 22'h0);
        end
        i_sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_preamble();
        obs_t exp;
        exp_pre = 2'b10;
        exp_q.push_back(make_exp(1'b0, 1'b0));
        drive_field(M_PRE, 8'b10, 2, EDGE_ALT, M_PRE);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL preamble_done: got %h expected %h", last_obs, exp);
        end
        checks++;
        if (last_early !== 1'b0) begin
            errors++;
            $display("[TB] FAIL preamble_early_done: got %b expected 0", last_early);
        end
        checks++;
        if (last_after !== 3'b000) begin
            errors++;
            $display("[TB] FAIL preamble_pulse_width: got %b expected 000", last_after);
        end
    endtask

    task automatic test_byte_parity();
        obs_t exp;
        logic [1:0] par;
        for (int pass = 0; pass < 2; pass++) begin
            exp_data = 8'hA5;
            exp_q.push_back(make_exp(1'b0, 1'b1));
            drive_field(M_BYTE, 8'hA5, 8, EDGE_ALT, M_BYTE);
            exp = exp_q.pop_front();
            checks++;
            if (last_obs !== exp) begin
                errors++;
                $display("[TB] FAIL byte_d1_%0d: got %h expected %h", pass, last_obs, exp);
            end
            exp_data = 8'h3C;
            exp_q.push_back(make_exp(1'b0, 1'b1));
            drive_field(M_BYTE, 8'h3C, 8, EDGE_ALT, M_BYTE);
            exp = exp_q.pop_front();
            checks++;
            if (last_obs !== exp) begin
                errors++;
                $display("[TB] FAIL byte_d2_%0d: got %h expected %h", pass, last_obs, exp);
            end
            checks++;
            if (last_after !== 3'b000) begin
                errors++;
                $display("[TB] FAIL byte_pulse_width_%0d: got %b expected 000", pass, last_after);
            end
            // First pass sends a wrong parity 00, second the correct one.
            par = (pass == 0) ? 2'b00 : model_parity(16'hA53C);
            exp_q.push_back(make_exp(par != model_parity(16'hA53C), 1'b0));
            drive_field(M_PARITY, {6'd0, par}, 2, EDGE_ALT, M_PARITY);
            exp = exp_q.pop_front();
            checks++;
            if (last_obs !== exp) begin
                errors++;
                $display("[TB] FAIL parity_%0d: got %h expected %h", pass, last_obs, exp);
            end
        end
    endtask

    task automatic test_token();
        obs_t exp;
        exp_q.push_back(make_exp(1'b0, 1'b0));
        drive_field(M_TOKEN, 8'b1100, 4, EDGE_ALT, M_TOKEN);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL token_good: got %h expected %h", last_obs, exp);
        end
        exp_q.push_back(make_exp(1'b1, 1'b0));
        drive_field(M_TOKEN, 8'b1101, 4, EDGE_ALT, M_TOKEN);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL token_bad: got %h expected %h", last_obs, exp);
        end
        // Mode input changed to BYTE after the first bit: still a token field.
        exp_q.push_back(make_exp(1'b0, 1'b0));
        drive_field(M_TOKEN, 8'b1100, 4, EDGE_ALT, M_BYTE);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL token_mode_change: got %h expected %h", last_obs, exp);
        end
    endtask

    task automatic test_crc();
        obs_t exp;
        logic crc_err;
`ifdef RX_CRC_CHECK_EN
        crc_err = 1'b1;
`else
        crc_err = 1'b0;
`endif
        i_crc_crc_value = 5'b10110;
        exp_q.push_back(make_exp(1'b0, 1'b0));
        drive_field(M_CRC, 8'b10110, 5, EDGE_ALT, M_CRC);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL crc_match: got %h expected %h", last_obs, exp);
        end
        i_crc_crc_value = 5'b10111;
        exp_q.push_back(make_exp(crc_err, 1'b0));
        drive_field(M_CRC, 8'b10110, 5, EDGE_ALT, M_CRC);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL crc_mismatch: got %h expected %h", last_obs, exp);
        end
        i_crc_crc_value = 5'd0;
    endtask

    task automatic test_abort();
        obs_t exp;
        logic bad;
        obs_t got;
        i_ddrccc_rx_en   = 1'b1;
        i_ddrccc_rx_mode = M_BYTE;
        tick();
        for (int i = 0; i < 4; i++) begin
            i_sdahnd_rx_sda       = 1'b1;
            i_sclgen_scl_pos_edge = (i % 2 == 0);
            i_sclgen_scl_neg_edge = (i % 2 == 1);
            tick();
        end
        i_sclgen_scl_pos_edge = 1'b0;
        i_sclgen_scl_neg_edge = 1'b0;
        i_ddrccc_rx_en = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = sample_outputs();
            if (got.done || got.wr || got.crc_en || got.err) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_pulse: got %b expected 0", bad);
        end
        checks++;
        if (got.rdata !== exp_data || got.pre !== exp_pre) begin
            errors++;
            $display("[TB] FAIL abort_hold: got data %h pre %b expected data %h pre %b",
                     got.rdata, got.pre, exp_data, exp_pre);
        end
        exp_data = 8'hFF;
        exp_q.push_back(make_exp(1'b0, 1'b1));
        drive_field(M_BYTE, 8'hFF, 8, EDGE_ALT, M_BYTE);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL abort_then_byte: got %h expected %h", last_obs, exp);
        end
    endtask

    task automatic test_undefined_mode();
        logic bad;
        bad = 1'b0;
        i_ddrccc_rx_en   = 1'b1;
        i_ddrccc_rx_mode = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            i_sdahnd_rx_sda       = 1'b1;
            i_sclgen_scl_pos_edge = (i % 2 == 0);
            i_sclgen_scl_neg_edge = (i % 2 == 1);
            tick();
            if (o_ddrccc_rx_mode_done || o_ddrccc_error || o_regf_wr_en) bad = 1'b1;
        end
        i_sclgen_scl_pos_edge = 1'b0;
        i_sclgen_scl_neg_edge = 1'b0;
        i_ddrccc_rx_en   = 1'b0;
        i_ddrccc_rx_mode = 4'd0;
        tick();
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL undefined_mode: got %b expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_and_both_edges();
        obs_t exp;
        obs_t got;
        i_ddrccc_rx_en   = 1'b1;
        i_ddrccc_rx_mode = M_BYTE;
        tick();
        for (int i = 0; i < 3; i++) begin
            i_sdahnd_rx_sda       = 1'b1;
            i_sclgen_scl_pos_edge = 1'b1;
            tick();
        end
        i_sys_rst             = 1'b1;
        i_sclgen_scl_pos_edge = 1'b1;
        i_sclgen_scl_neg_edge = 1'b1;
        tick();
        i_sclgen_scl_pos_edge = 1'b0;
        i_sclgen_scl_neg_edge = 1'b0;
        got = sample_outputs();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_field: got %h expected %h", got, 22'h0);
        end
        i_sys_rst      = 1'b0;
        i_ddrccc_rx_en = 1'b0;
        tick();
        exp_pre  = 2'b00;
        exp_data = 8'h5A;
        exp_q.push_back(make_exp(1'b0, 1'b1));
        drive_field(M_BYTE, 8'h5A, 8, EDGE_BOTH, M_BYTE);
        exp = exp_q.pop_front();
        checks++;
        if (last_obs !== exp) begin
            errors++;
            $display("[TB] FAIL both_edges_byte: got %h expected %h", last_obs, exp);
        end
        checks++;
        if (last_early !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_edges_early_done: got %b expected 0", last_early);
        end
    endtask

    initial begin
        checks                = 0;
        errors                = 0;
        exp_pre               = 2'b00;
        exp_data              = 8'h00;
        last_obs              = '0;
        last_early            = 1'b0;
        last_after            = 3'b000;
        i_sys_rst             = 1'b1;
        i_ddrccc_rx_en        = 1'b0;
        i_ddrccc_rx_mode      = 4'd0;
        i_sclgen_scl_pos_edge = 1'b0;
        i_sclgen_scl_neg_edge = 1'b0;
        i_sdahnd_rx_sda       = 1'b0;
        i_crc_crc_value       = 5'd0;

        $display("[TB] ddr_rx directed tests start");
        test_reset();
        test_preamble();
        test_byte_parity();
        test_token();
        test_crc();
        test_abort();
        test_undefined_mode();
        test_reset_mid_and_both_edges();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
